// File: rtl/curve25519_pkg.sv
// Shared constants, FSM encoding and modular helpers for the Curve25519 datapath.
// Used by the projective-to-affine converter and reusable by the ladder.
package curve25519_pkg;

    localparam int WIDTH = 255;
    // One operand-load cycle plus one cycle per bit of the serial multiplier.
    localparam int MUL_LAT = WIDTH + 1;

    // p = 2^255 - 19
    localparam logic [WIDTH-1:0] PRIME     = {{(WIDTH-5){1'b1}}, 5'b01101};
    localparam logic [WIDTH-1:0] P_MINUS_2 = {{(WIDTH-5){1'b1}}, 5'b01011};

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL,
        NEXT,
        FIN,
        DONE
    } state_t;

    // Brings any value in [0, 2^255) into [0, p); one subtraction suffices since 2^255 < 2p.
    function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH-1:0] v);
        return (v >= PRIME) ? (v - PRIME) : v;
    endfunction

    // One interleaved step: 2*acc + (b_bit ? a : 0), with acc, a < p the sum is below 3p.
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             b_bit);
        logic [WIDTH+1:0] t;
        t = {1'b0, acc, 1'b0} + (b_bit ? {2'b00, a} : {(WIDTH+2){1'b0}});
        if (t >= {2'b00, PRIME}) t = t - {2'b00, PRIME};
        if (t >= {2'b00, PRIME}) t = t - {2'b00, PRIME};
        return t[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mod_mul_25519.sv
// Bit-serial MSB-first interleaved modular multiplier, y = a*b mod p.
// done pulses in the MUL_LAT-th cycle after start is sampled; y holds until the next start.
module mod_mul_25519
    import curve25519_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             done
);

    localparam logic [7:0] LAST_STEP = 8'(WIDTH - 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [7:0]       cnt;
    logic             run;

    // NOTE: the operand and accumulator registers are reset too, so no stale
    // product from an aborted job can ever reach y after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            // NOTE: default-then-override with non-blocking assignments; the
            // last assignment in the block wins, so done is a single-cycle pulse.
            done <= 1'b0;
            if (start) begin
                a_q <= reduce_once(a);
                b_q <= b;
                acc <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                acc <= mul_step(acc, a_q, b_q[WIDTH-1]);
                b_q <= {b_q[WIDTH-2:0], 1'b0};
                cnt <= cnt + 8'd1;
                if (cnt == LAST_STEP) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign y = acc;

endmodule

// File: rtl/proj_to_affine.sv
// Converts ladder output (X:Z) to affine x = X * Z^(p-2) mod p using Fermat
// inversion (left-to-right square-and-multiply) on one shared serial multiplier.
module proj_to_affine
    import curve25519_pkg::*;
(
    input  logic             aff_clk,
    input  logic             aff_reset_n,
    input  logic             aff_valid,
    input  logic [WIDTH-1:0] X_in,
    input  logic [WIDTH-1:0] Z_in,
    output logic [WIDTH-1:0] aff_x,
    output logic             aff_data_valid,
    output logic             aff_busy
);

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] acc;
    logic [7:0]       idx;
    logic             launched;
    logic             mul_start;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_y;
    logic             mul_done;

    // The multiplier samples its operands one cycle after the FSM issues start,
    // so the selection follows the state that is current at that sample edge.
    always_comb begin
        mul_b = acc;
        case (state)
            MUL:     mul_b = z_q;
            FIN:     mul_b = x_q;
            default: mul_b = acc;
        endcase
    end

    mod_mul_25519 u_mul (
        .clk     (aff_clk),
        .reset_n (aff_reset_n),
        .start   (mul_start),
        .a       (acc),
        .b       (mul_b),
        .y       (mul_y),
        .done    (mul_done)
    );

    // Each done edge launches the following multiply immediately. NEXT is
    // occupied while that squaring runs, so the index bookkeeping adds no time.
    always_ff @(posedge aff_clk or negedge aff_reset_n) begin
        if (!aff_reset_n) begin
            state          <= IDLE;
            x_q            <= '0;
            z_q            <= '0;
            acc            <= '0;
            idx            <= '0;
            launched       <= 1'b0;
            mul_start      <= 1'b0;
            aff_x          <= '0;
            aff_data_valid <= 1'b0;
            aff_busy       <= 1'b0;
        end else begin
            mul_start      <= 1'b0;
            aff_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    aff_busy <= aff_valid;
                    if (aff_valid) begin
                        x_q      <= X_in;
                        z_q      <= Z_in;
                        acc      <= WIDTH'(1);
                        idx      <= 8'(WIDTH - 1);
                        launched <= 1'b0;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    if (!launched) begin
                        mul_start <= 1'b1;
                        launched  <= 1'b1;
                    end else if (mul_done) begin
                        acc       <= mul_y;
                        mul_start <= 1'b1;
                        if (P_MINUS_2[idx])   state <= MUL;
                        else if (idx == '0)   state <= FIN;
                        else                  state <= NEXT;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        acc       <= mul_y;
                        mul_start <= 1'b1;
                        state     <= (idx == '0) ? FIN : NEXT;
                    end
                end
                NEXT: begin
                    idx   <= idx - 8'd1;
                    state <= SQR;
                end
                FIN: begin
                    if (mul_done) begin
                        acc   <= mul_y;
                        state <= DONE;
                    end
                end
                DONE: begin
                    aff_x          <= acc;
                    aff_data_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
